// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage buffer: control-vector bit positions
// and default widths.
package pipe_pkg;

  localparam int unsigned PAYLOAD_W_DEF = 192;
  localparam int unsigned CTRL_W_DEF    = 16;
  localparam int unsigned OCC_W         = 2;

  localparam int unsigned CTRL_LUI     = 0;
  localparam int unsigned CTRL_CSR_WE  = 1;
  localparam int unsigned CTRL_JAL     = 2;
  localparam int unsigned CTRL_FENCE   = 3;
  localparam int unsigned CTRL_JALR    = 4;
  localparam int unsigned CTRL_AUIPC   = 5;
  localparam int unsigned CTRL_BRANCH  = 6;
  localparam int unsigned CTRL_ALU_SRC = 7;
  localparam int unsigned CTRL_MEM_RD  = 8;
  localparam int unsigned CTRL_MEM_WR  = 9;
  localparam int unsigned CTRL_MEM2REG = 10;
  localparam int unsigned CTRL_REG_WR  = 11;
  localparam int unsigned CTRL_ECALL   = 12;
  localparam int unsigned CTRL_EBREAK  = 13;
  localparam int unsigned CTRL_MRET    = 14;

  // Entry count after one cycle of push/pop activity.
  function automatic logic [OCC_W-1:0] occ_next(input logic [OCC_W-1:0] occ,
                                                input logic             push,
                                                input logic             pop);
    return occ + OCC_W'(push) - OCC_W'(pop);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One buffered pipeline entry: valid flag, memory-type flag, control vector and payload.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int unsigned CTRL_W    = CTRL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_clear,
  input  logic                 i_mem_type,
  input  logic [CTRL_W-1:0]    i_ctrl,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output logic                 o_valid,
  output logic                 o_mem_type,
  output logic [CTRL_W-1:0]    o_ctrl,
  output logic [PAYLOAD_W-1:0] o_payload
);

  logic                 r_valid;
  logic                 r_mem_type;
  logic [CTRL_W-1:0]    r_ctrl;
  logic [PAYLOAD_W-1:0] r_payload;

  // Clear wins over load for the valid flag; data registers only move on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_mem_type <= 1'b0;
      r_ctrl     <= '0;
      r_payload  <= '0;
    end else begin
      if (i_clear) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
      end
      if (i_load) begin
        r_mem_type <= i_mem_type;
        r_ctrl     <= i_ctrl;
        r_payload  <= i_payload;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_mem_type = r_mem_type;
  assign o_ctrl     = r_ctrl;
  assign o_payload  = r_payload;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer with optional skid entry, memory-address handshake on
// the head entry, flush controls and a saturating head-stall counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int unsigned CTRL_W    = CTRL_W_DEF,
  parameter int unsigned SKID      = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 flush_stage,
  input  logic                 hold,
  input  logic                 valid_pre,
  input  logic                 ready_go_pre,
  output logic                 allow_in,
  input  logic [PAYLOAD_W-1:0] payload_in,
  input  logic [CTRL_W-1:0]    ctrl_in,
  input  logic                 mem_type_in,
  output logic                 valid_out,
  output logic                 ready_go_out,
  output logic [PAYLOAD_W-1:0] payload_out,
  output logic [CTRL_W-1:0]    ctrl_out,
  input  logic                 allow_in_next,
  output logic                 mem_req,
  input  logic                 mem_addr_ok,
  output logic [OCC_W-1:0]     occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int unsigned NSLOT = 1 + SKID;

  logic                 r_head;
  logic                 r_tail;
  logic [OCC_W-1:0]     r_occ;
  logic [CNT_W-1:0]     r_stall;

  logic                 w_slot_load  [NSLOT];
  logic                 w_slot_clear [NSLOT];
  logic                 w_slot_valid [NSLOT];
  logic                 w_slot_mt    [NSLOT];
  logic [CTRL_W-1:0]    w_slot_ctrl  [NSLOT];
  logic [PAYLOAD_W-1:0] w_slot_pay   [NSLOT];

  logic                 w_head_valid;
  logic                 w_head_mt;
  logic [CTRL_W-1:0]    w_head_ctrl;
  logic [PAYLOAD_W-1:0] w_head_pay;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_mem_req;
  logic                 w_ready_go;
  logic                 w_allow_in;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    assign w_slot_load[i]  = w_push && !flush_stage && (r_tail == 1'(i));
    assign w_slot_clear[i] = flush_stage ||
                             (w_pop && (r_head == 1'(i)) && !w_slot_load[i]);

    pipe_slot #(
      .PAYLOAD_W (PAYLOAD_W),
      .CTRL_W    (CTRL_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_slot_load[i]),
      .i_clear    (w_slot_clear[i]),
      .i_mem_type (mem_type_in),
      .i_ctrl     (ctrl_in),
      .i_payload  (payload_in),
      .o_valid    (w_slot_valid[i]),
      .o_mem_type (w_slot_mt[i]),
      .o_ctrl     (w_slot_ctrl[i]),
      .o_payload  (w_slot_pay[i])
    );
  end

  // Head select; allow_in is registered-only in the skid build so it never
  // depends on downstream readiness.
  if (SKID != 0) begin : g_skid
    assign w_head_valid = r_head ? w_slot_valid[1] : w_slot_valid[0];
    assign w_head_mt    = r_head ? w_slot_mt[1]    : w_slot_mt[0];
    assign w_head_ctrl  = r_head ? w_slot_ctrl[1]  : w_slot_ctrl[0];
    assign w_head_pay   = r_head ? w_slot_pay[1]   : w_slot_pay[0];
    assign w_allow_in   = (r_occ < 2'd2);
  end else begin : g_single
    assign w_head_valid = w_slot_valid[0];
    assign w_head_mt    = w_slot_mt[0];
    assign w_head_ctrl  = w_slot_ctrl[0];
    assign w_head_pay   = w_slot_pay[0];
    assign w_allow_in   = !w_head_valid || w_pop;
  end

  always_comb begin
    w_mem_req  = w_head_valid && w_head_mt && allow_in_next && !hold;
    w_ready_go = w_head_mt ? (w_mem_req && mem_addr_ok) : !hold;
    w_pop      = w_head_valid && w_ready_go && allow_in_next && !hold;
    w_push     = valid_pre && ready_go_pre && !flush && w_allow_in;
  end

  // Head/tail pointers only toggle when a second slot exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_occ  <= '0;
    end else if (flush_stage) begin
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_occ  <= '0;
    end else begin
      if (w_push && (SKID != 0)) begin
        r_tail <= ~r_tail;
      end
      if (w_pop && (SKID != 0)) begin
        r_head <= ~r_head;
      end
      r_occ <= occ_next(r_occ, w_push, w_pop);
    end
  end

  // Stall counter saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (w_head_valid && !w_pop && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign allow_in     = w_allow_in;
  assign valid_out    = w_head_valid;
  assign ready_go_out = w_ready_go;
  assign payload_out  = w_head_pay;
  assign ctrl_out     = w_head_ctrl & {CTRL_W{w_head_valid}};
  assign mem_req      = w_mem_req;
  assign occupancy    = r_occ;
  assign stall_cnt    = r_stall;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a skid instance (a_*) and a single-entry
// instance (b_*) share clock and reset.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_flush = 0, a_fs = 0, a_hold = 0, a_vp = 0, a_rgp = 0;
  logic        a_mt = 0, a_ain_next = 0, a_ok = 0;
  logic [31:0] a_pay = 0;
  logic [15:0] a_ctrl = 0;
  logic        a_ain, a_vo, a_rgo, a_mreq;
  logic [31:0] a_pout;
  logic [15:0] a_cout;
  logic [1:0]  a_occ;
  logic [3:0]  a_stall;

  logic        b_flush = 0, b_fs = 0, b_hold = 0, b_vp = 0, b_rgp = 0;
  logic        b_mt = 0, b_ain_next = 0, b_ok = 0;
  logic [31:0] b_pay = 0;
  logic [15:0] b_ctrl = 0;
  logic        b_ain, b_vo, b_rgo, b_mreq;
  logic [31:0] b_pout;
  logic [15:0] b_cout;
  logic [1:0]  b_occ;
  logic [15:0] b_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.PAYLOAD_W(32), .CTRL_W(16), .SKID(1), .CNT_W(4)) u_dut_skid (
    .clk(clk), .rst(rst), .flush(a_flush), .flush_stage(a_fs), .hold(a_hold),
    .valid_pre(a_vp), .ready_go_pre(a_rgp), .allow_in(a_ain),
    .payload_in(a_pay), .ctrl_in(a_ctrl), .mem_type_in(a_mt),
    .valid_out(a_vo), .ready_go_out(a_rgo), .payload_out(a_pout),
    .ctrl_out(a_cout), .allow_in_next(a_ain_next), .mem_req(a_mreq),
    .mem_addr_ok(a_ok), .occupancy(a_occ), .stall_cnt(a_stall)
  );

  pipe_stage_buf #(.PAYLOAD_W(32), .CTRL_W(16), .SKID(0), .CNT_W(16)) u_dut_single (
    .clk(clk), .rst(rst), .flush(b_flush), .flush_stage(b_fs), .hold(b_hold),
    .valid_pre(b_vp), .ready_go_pre(b_rgp), .allow_in(b_ain),
    .payload_in(b_pay), .ctrl_in(b_ctrl), .mem_type_in(b_mt),
    .valid_out(b_vo), .ready_go_out(b_rgo), .payload_out(b_pout),
    .ctrl_out(b_cout), .allow_in_next(b_ain_next), .mem_req(b_mreq),
    .mem_addr_ok(b_ok), .occupancy(b_occ), .stall_cnt(b_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_flush = 0; a_fs = 0; a_hold = 0; a_vp = 0; a_rgp = 0;
    a_mt = 0; a_ain_next = 0; a_ok = 0; a_pay = 0; a_ctrl = 0;
  endtask

  task automatic do_reset();
    a_idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2;
    check("rst_occ",    64'(a_occ),   64'd0);
    check("rst_vo",     64'(a_vo),    64'd0);
    check("rst_cout",   64'(a_cout),  64'd0);
    check("rst_pout",   64'(a_pout),  64'd0);
    check("rst_mreq",   64'(a_mreq),  64'd0);
    check("rst_stall",  64'(a_stall), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rel_ain_skid",   64'(a_ain), 64'd1);
    check("rel_ain_single", 64'(b_ain), 64'd1);

    // Fill both skid entries under back-pressure, then drain in order
    a_rgp = 1; a_vp = 1; a_pay = 32'h11; a_ctrl = 16'h00F1;
    tick();
    check("fill1_occ",  64'(a_occ),  64'd1);
    check("fill1_vo",   64'(a_vo),   64'd1);
    check("fill1_pout", 64'(a_pout), 64'h11);
    check("fill1_cout", 64'(a_cout), 64'h00F1);
    check("fill1_ain",  64'(a_ain),  64'd1);
    a_pay = 32'h22; a_ctrl = 16'h00F2;
    tick();
    check("fill2_occ",  64'(a_occ),  64'd2);
    check("fill2_ain",  64'(a_ain),  64'd0);
    check("fill2_pout", 64'(a_pout), 64'h11);
    a_vp = 0; a_ain_next = 1;
    #1;
    check("drain_rgo",  64'(a_rgo),  64'd1);
    check("drain_ain_same_cycle", 64'(a_ain), 64'd0);
    tick();
    check("pop1_occ",  64'(a_occ),  64'd1);
    check("pop1_pout", 64'(a_pout), 64'h22);
    check("pop1_cout", 64'(a_cout), 64'h00F2);
    check("pop1_ain",  64'(a_ain),  64'd1);
    tick();
    check("pop2_occ",  64'(a_occ),  64'd0);
    check("pop2_vo",   64'(a_vo),   64'd0);
    check("pop2_cout", 64'(a_cout), 64'd0);

    // Push and pop in the same cycle at occupancy 1
    a_vp = 1; a_pay = 32'h33; a_ctrl = 16'h0033;
    tick();
    check("pp_pre_occ", 64'(a_occ), 64'd1);
    a_pay = 32'h44; a_ctrl = 16'h0044;
    tick();
    check("pp_occ",  64'(a_occ),  64'd1);
    check("pp_pout", 64'(a_pout), 64'h44);
    a_vp = 0;
    tick();
    check("pp_drain_occ", 64'(a_occ), 64'd0);

    // Memory handshake stalls the head until mem_addr_ok
    do_reset();
    a_rgp = 1; a_vp = 1; a_mt = 1; a_pay = 32'h55; a_ctrl = 16'h0300;
    a_ain_next = 1; a_ok = 0;
    tick();
    check("mem_vo", 64'(a_vo), 64'd1);
    a_vp = 0; a_mt = 0;
    #1;
    check("mem_req",    64'(a_mreq), 64'd1);
    check("mem_rgo_lo", 64'(a_rgo),  64'd0);
    repeat (3) tick();
    check("mem_wait_req",   64'(a_mreq),  64'd1);
    check("mem_wait_vo",    64'(a_vo),    64'd1);
    check("mem_wait_stall", 64'(a_stall), 64'd3);
    a_ok = 1;
    #1;
    check("mem_ok_rgo", 64'(a_rgo), 64'd1);
    tick();
    check("mem_pop_occ",   64'(a_occ),   64'd0);
    check("mem_pop_vo",    64'(a_vo),    64'd0);
    check("mem_pop_stall", 64'(a_stall), 64'd3);
    a_ok = 0;

    // hold masks the memory request without disturbing the head
    a_vp = 1; a_mt = 1; a_pay = 32'h66; a_ctrl = 16'h0400;
    tick();
    a_vp = 0; a_mt = 0; a_hold = 1; a_ok = 1;
    #1;
    check("hold_mreq", 64'(a_mreq), 64'd0);
    check("hold_rgo",  64'(a_rgo),  64'd0);
    check("hold_cout", 64'(a_cout), 64'h0400);
    tick();
    check("hold_occ",   64'(a_occ),  64'd1);
    check("hold_cout2", 64'(a_cout), 64'h0400);
    check("hold_mreq2", 64'(a_mreq), 64'd0);
    a_hold = 0;
    #1;
    check("unhold_mreq", 64'(a_mreq), 64'd1);
    check("unhold_rgo",  64'(a_rgo),  64'd1);
    tick();
    check("unhold_occ",   64'(a_occ),   64'd0);
    check("unhold_stall", 64'(a_stall), 64'd4);
    a_ok = 0;

    // flush kills the incoming transfer; stall counter saturates
    a_ain_next = 0; a_vp = 1; a_mt = 0; a_pay = 32'h77; a_ctrl = 16'h0077;
    tick();
    check("fl_pre_occ", 64'(a_occ), 64'd1);
    a_flush = 1; a_pay = 32'h88; a_ctrl = 16'h0088;
    tick();
    check("flush_occ",  64'(a_occ),  64'd1);
    check("flush_pout", 64'(a_pout), 64'h77);
    a_flush = 0; a_vp = 0;
    repeat (12) tick();
    check("stall_sat",  64'(a_stall), 64'hF);
    repeat (3) tick();
    check("stall_nowrap", 64'(a_stall), 64'hF);

    // flush_stage empties a full buffer
    a_vp = 1; a_pay = 32'h99; a_ctrl = 16'h0099;
    tick();
    check("fs_full_occ", 64'(a_occ), 64'd2);
    check("fs_full_ain", 64'(a_ain), 64'd0);
    a_vp = 0; a_fs = 1;
    tick();
    check("fs_occ",  64'(a_occ),  64'd0);
    check("fs_cout", 64'(a_cout), 64'd0);
    check("fs_vo",   64'(a_vo),   64'd0);
    check("fs_ain",  64'(a_ain),  64'd1);
    a_fs = 0;

    // flush_stage with an accepted memory request and a coincident push
    a_ain_next = 1; a_vp = 1; a_mt = 1; a_pay = 32'hAA; a_ctrl = 16'h00AA; a_ok = 1;
    tick();
    check("fsm_occ", 64'(a_occ), 64'd1);
    a_fs = 1; a_mt = 0; a_pay = 32'hBB; a_ctrl = 16'h00BB;
    #1;
    check("fsm_mreq", 64'(a_mreq), 64'd1);
    tick();
    check("fsm_after_occ", 64'(a_occ), 64'd0);
    check("fsm_after_vo",  64'(a_vo),  64'd0);
    a_fs = 0; a_vp = 0; a_ok = 0;

    // Asynchronous reset in the middle of a handshake
    a_ain_next = 0; a_vp = 1; a_mt = 1; a_pay = 32'hC1; a_ctrl = 16'h00C1;
    tick();
    a_pay = 32'hC2; a_ctrl = 16'h00C2;
    tick();
    check("ar_occ", 64'(a_occ), 64'd2);
    a_vp = 0; a_ain_next = 1; a_ok = 0;
    #1;
    check("ar_mreq_pre", 64'(a_mreq), 64'd1);
    rst = 1'b1;
    #1;
    check("ar_mreq",  64'(a_mreq),  64'd0);
    check("ar_vo",    64'(a_vo),    64'd0);
    check("ar_occ0",  64'(a_occ),   64'd0);
    check("ar_cout",  64'(a_cout),  64'd0);
    check("ar_stall", 64'(a_stall), 64'd0);
    #1;
    rst = 1'b0;
    a_idle();
    #1;
    check("ar_ain", 64'(a_ain), 64'd1);

    // Single-entry stage: streaming at one entry per cycle
    tick();
    b_ain_next = 1; b_rgp = 1;
    for (int k = 0; k < 6; k++) begin
      b_vp = 1; b_pay = 32'h100 + 32'(k); b_ctrl = 16'(k + 1);
      #1;
      check("str_ain", 64'(b_ain), 64'd1);
      tick();
      check("str_vo",   64'(b_vo),   64'd1);
      check("str_pout", 64'(b_pout), 64'h100 + 64'(k));
      check("str_cout", 64'(b_cout), 64'(k + 1));
      check("str_occ",  64'(b_occ),  64'd1);
    end
    b_vp = 0;
    tick();
    check("str_end_occ", 64'(b_occ), 64'd0);
    check("str_end_vo",  64'(b_vo),  64'd0);

    // Single-entry stage under back-pressure
    b_ain_next = 0; b_vp = 1; b_pay = 32'h200; b_ctrl = 16'h0200;
    tick();
    b_vp = 0;
    #1;
    check("bp_ain_blocked", 64'(b_ain), 64'd0);
    b_ain_next = 1;
    #1;
    check("bp_ain_pop", 64'(b_ain), 64'd1);
    tick();
    check("bp_occ", 64'(b_occ), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL provide parameter PAYLOAD_W, default 192, meaning width of the unqualified payload (pc, rs data, imm, instruction, csr data, register indices).
REQ-002 SHALL provide parameter CTRL_W, default 16, meaning width of the control vector that is masked by valid at the output.
REQ-003 SHALL provide parameter SKID, default 1, meaning 0 gives a single-entry stage and 1 gives a two-entry skid stage.
REQ-004 SHALL provide parameter CNT_W, default 16, meaning width of the stall performance counter.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 flush  in  1  kill the incoming transfer this cycle.
REQ-008 flush_stage  in  1  discard every stored entry.
REQ-009 hold  in  1  freeze the head entry and suppress mem_req.
REQ-010 valid_pre  in  1  upstream stage holds a valid entry.
REQ-011 ready_go_pre  in  1  upstream entry is ready to leave.
REQ-012 allow_in  out  1  this stage accepts an entry this cycle.
REQ-013 payload_in  in  PAYLOAD_W  incoming payload.
REQ-014 ctrl_in  in  CTRL_W  incoming control vector.
REQ-015 mem_type_in  in  1  the incoming entry needs a memory address handshake.
REQ-016 valid_out  out  1  the head entry is valid.
REQ-017 ready_go_out  out  1  the head entry is ready to leave.
REQ-018 payload_out  out  PAYLOAD_W  head payload, not masked.
REQ-019 ctrl_out  out  CTRL_W  head control vector ANDed with valid_out.
REQ-020 allow_in_next  in  1  the downstream stage accepts.
REQ-021 mem_req  out  1  memory request strobe.
REQ-022 mem_addr_ok  in  1  memory accepted the address.
REQ-023 occupancy  out  2  number of stored entries, 0 to 1+SKID.
REQ-024 stall_cnt  out  CNT_W  saturating count of head-stall cycles.

Function
REQ-025 The stage SHALL push an entry when valid_pre & ready_go_pre & !flush & allow_in.
REQ-026 mem_req SHALL equal valid_out & head mem_type & allow_in_next & !hold.
REQ-027 ready_go_out SHALL equal (mem_req & mem_addr_ok) when head mem_type=1, and !hold otherwise.
REQ-028 The head SHALL pop when valid_out & ready_go_out & allow_in_next & !hold.
REQ-029 With SKID=0, allow_in SHALL equal !valid_out | pop, so push and pop can occur in the same cycle.
REQ-030 With SKID=1, allow_in SHALL equal (occupancy<2), a registered-only term independent of allow_in_next and hold.
REQ-031 Entries SHALL leave in FIFO order; a push into an empty stage SHALL be visible at the outputs on the next cycle (1-cycle latency).
REQ-032 With SKID=1, occupancy=1, and push and pop in the same cycle, occupancy SHALL stay 1 and the new entry SHALL become the head.
REQ-033 With SKID=1 and occupancy=2, no push SHALL occur; a pop SHALL make the second entry the head and raise allow_in on the next cycle.
REQ-034 Payload and ctrl registers SHALL load only on push and SHALL hold their value otherwise; a slot that is not valid SHALL NOT be read.
REQ-035 flush_stage SHALL clear all entries on the next edge, including a push in the same cycle.
REQ-036 If flush_stage coincides with mem_req & mem_addr_ok, the request SHALL still be issued and the entry SHALL still be discarded.
REQ-037 stall_cnt SHALL increment each cycle valid_out & !pop holds, saturate at all-ones, and never wrap.
REQ-038 hold asserted with mem_type=1 SHALL keep mem_req=0 and ready_go_out=0 until hold drops.

Reset
REQ-039 While rst=1, occupancy, valid_out, ctrl_out, mem_req, stall_cnt and all payload and ctrl registers SHALL be 0.
REQ-040 After reset, allow_in SHALL be 1.
REQ-041 Reset asserted mid-handshake SHALL drop mem_req immediately and SHALL NOT wait for a clock edge.

Structure
REQ-042 Package pipe_pkg SHALL hold the ctrl bit-position constants (LUI, CSR_WE, JAL, FENCE, JALR, AUIPC, BRANCH, ALU_SRC, MEM_RD, MEM_WR, MEM2REG, REG_WR, ECALL, EBREAK, MRET) and the CTRL_W default.
REQ-043 One sub-module, pipe_slot, SHALL hold a single {valid, mem_type, ctrl, payload} entry with a load enable and a clear input.
REQ-044 The stage SHALL be built from 1+SKID instances of pipe_slot plus head/tail pointer logic.

Verification
REQ-045 SKID=1, allow_in_next=0, push A then B -> occupancy=2 and allow_in=0; then allow_in_next=1 -> A pops, then B pops, and allow_in=1 one cycle after the first pop.
REQ-046 Head mem_type=1, mem_addr_ok low for 3 cycles -> mem_req stays high, valid_out stays high and stall_cnt=3; mem_addr_ok=1 -> the head pops that cycle.
REQ-047 hold=1 with a valid mem-type head -> mem_req=0 and ctrl_out unchanged; hold=0 -> mem_req=1 on the same cycle.
REQ-048 flush=1 with valid_pre=1 -> no push and occupancy unchanged; flush_stage=1 with occupancy=2 -> occupancy=0 and ctrl_out=0 on the next cycle.
REQ-049 SKID=0, continuous stream with allow_in_next=1 -> one entry per cycle, allow_in stays 1 and the output matches the input delayed by one cycle.
REQ-050 rst pulsed while occupancy=2 and mem_req=1 -> all outputs go to 0 asynchronously and allow_in=1 after release.
